// File: rtl/pga_pkg.sv
// Shared definitions for the PGA offset-calibration sequencer: FSM encoding,
// PGA field widths and default timing parameters.
package pga_pkg;

  localparam int OFFSET_W          = 5;
  localparam int GAIN_W            = 4;
  localparam int CNT_W             = 16;
  localparam int SETTLE_CYCLES_DEF = 1000;
  localparam int ACK_TIMEOUT_DEF   = 255;

  typedef enum logic [3:0] {
    LINK_WAIT,
    IDLE,
    VOS_REQ,
    VOS_ACK,
    GAIN_REQ,
    GAIN_ACK,
    SETTLE,
    SAMPLE,
    FINAL_VOS,
    DONE
  } state_t;

endpackage

// File: rtl/pga_sync2.sv
// Two-flop synchronizer for a single asynchronous level into the clk domain.
module pga_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/pga_sequencer.sv
// Drives PGA gain/offset writes through the serializer handshake and runs an
// offset sweep that stops at the first comparator trip.
module pga_sequencer
  import pga_pkg::*;
#(
  parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter int ACK_TIMEOUT   = ACK_TIMEOUT_DEF
) (
  input  logic                clk50,
  input  logic                wb_rst,
  input  logic                start_write,
  input  logic                start_cal,
  input  logic [OFFSET_W-1:0] cfg_offset,
  input  logic [GAIN_W-1:0]   cfg_gain,
  input  logic                cfg_shdn,
  input  logic                cfg_meas,
  input  logic                cmp_in,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [OFFSET_W-1:0] cal_offset,
  output logic                cal_found,
  output logic                pga_set_vos,
  output logic                pga_set_gain,
  output logic [OFFSET_W-1:0] pga_offset,
  output logic [GAIN_W-1:0]   pga_gain,
  output logic                pga_shdn,
  output logic                pga_meas,
  input  logic                pga_ready
);

  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic ready_s, cmp_s;

  pga_sync2 u_sync_ready (.clk(clk50), .rst(wb_rst), .d(pga_ready), .q(ready_s));
  pga_sync2 u_sync_cmp   (.clk(clk50), .rst(wb_rst), .d(cmp_in),    .q(cmp_s));

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OFFSET_W-1:0]  k_q, k_d;
  logic                 trip_q, trip_d;
  logic                 cal_mode_q, cal_mode_d;
  logic                 final_q, final_d;
  logic                 meas_save_q, meas_save_d;
  logic                 error_q, error_d;
  logic [OFFSET_W-1:0]  cal_offset_q, cal_offset_d;
  logic                 cal_found_q, cal_found_d;
  logic [OFFSET_W-1:0]  pga_offset_q, pga_offset_d;
  logic [GAIN_W-1:0]    pga_gain_q, pga_gain_d;
  logic                 pga_shdn_q, pga_shdn_d;
  logic                 pga_meas_q, pga_meas_d;
  logic                 timed_out;

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    k_d          = k_q;
    trip_d       = trip_q;
    cal_mode_d   = cal_mode_q;
    final_d      = final_q;
    meas_save_d  = meas_save_q;
    error_d      = error_q;
    cal_offset_d = cal_offset_q;
    cal_found_d  = cal_found_q;
    pga_offset_d = pga_offset_q;
    pga_gain_d   = pga_gain_q;
    pga_shdn_d   = pga_shdn_q;
    pga_meas_d   = pga_meas_q;
    busy         = 1'b1;
    done         = 1'b0;
    pga_set_vos  = 1'b0;
    pga_set_gain = 1'b0;
    timed_out    = (cnt_q == ACK_LAST);

    case (state_q)
      LINK_WAIT: if (ready_s) state_d = IDLE;
      IDLE: begin
        busy = 1'b0;
        // Fields for the first packet are loaded here so they are already
        // stable in the cycle the gain request rises.
        if (start_cal || start_write) begin
          error_d    = 1'b0;
          final_d    = 1'b0;
          pga_gain_d = cfg_gain;
          pga_shdn_d = cfg_shdn;
          state_d    = GAIN_REQ;
          if (start_cal) begin
            cal_mode_d   = 1'b1;
            k_d          = '0;
            trip_d       = 1'b0;
            meas_save_d  = cfg_meas;
            pga_meas_d   = 1'b1;
            pga_offset_d = '0;
          end else begin
            cal_mode_d   = 1'b0;
            pga_meas_d   = cfg_meas;
            pga_offset_d = cfg_offset;
          end
        end
      end
      GAIN_REQ: begin
        pga_set_gain = 1'b1;
        cnt_d        = cnt_q + 1'b1;
        if (!ready_s) state_d = GAIN_ACK;
        else if (timed_out) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end
      GAIN_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (ready_s) state_d = VOS_REQ;
        else if (timed_out) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end
      VOS_REQ: begin
        pga_set_vos = 1'b1;
        cnt_d       = cnt_q + 1'b1;
        if (!ready_s) state_d = VOS_ACK;
        else if (timed_out) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end
      VOS_ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (ready_s) state_d = (cal_mode_q && !final_q) ? SETTLE : DONE;
        else if (timed_out) begin
          error_d = 1'b1;
          state_d = DONE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == SETTLE_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        // k saturates at 31: the last step without a trip ends the sweep.
        if (cmp_s) begin
          trip_d  = 1'b1;
          state_d = FINAL_VOS;
        end else if (k_q == '1) begin
          trip_d  = 1'b0;
          state_d = FINAL_VOS;
        end else begin
          k_d          = k_q + 1'b1;
          pga_offset_d = k_q + 1'b1;
          state_d      = VOS_REQ;
        end
      end
      FINAL_VOS: begin
        final_d      = 1'b1;
        pga_offset_d = k_q;
        pga_meas_d   = meas_save_q;
        state_d      = VOS_REQ;
      end
      DONE: begin
        done = 1'b1;
        if (cal_mode_q && !error_q) begin
          cal_offset_d = k_q;
          cal_found_d  = trip_q;
        end
        state_d = error_q ? LINK_WAIT : IDLE;
      end
      default: state_d = LINK_WAIT;
    endcase

    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk50 or posedge wb_rst) begin
    if (wb_rst) begin
      state_q      <= LINK_WAIT;
      cnt_q        <= '0;
      k_q          <= '0;
      trip_q       <= 1'b0;
      cal_mode_q   <= 1'b0;
      final_q      <= 1'b0;
      meas_save_q  <= 1'b0;
      error_q      <= 1'b0;
      cal_offset_q <= '0;
      cal_found_q  <= 1'b0;
      pga_offset_q <= '0;
      pga_gain_q   <= '0;
      pga_shdn_q   <= 1'b0;
      pga_meas_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      k_q          <= k_d;
      trip_q       <= trip_d;
      cal_mode_q   <= cal_mode_d;
      final_q      <= final_d;
      meas_save_q  <= meas_save_d;
      error_q      <= error_d;
      cal_offset_q <= cal_offset_d;
      cal_found_q  <= cal_found_d;
      pga_offset_q <= pga_offset_d;
      pga_gain_q   <= pga_gain_d;
      pga_shdn_q   <= pga_shdn_d;
      pga_meas_q   <= pga_meas_d;
    end
  end

  assign error      = error_q;
  assign cal_offset = cal_offset_q;
  assign cal_found  = cal_found_q;
  assign pga_offset = pga_offset_q;
  assign pga_gain   = pga_gain_q;
  assign pga_shdn   = pga_shdn_q;
  assign pga_meas   = pga_meas_q;

endmodule

// File: tb/tb_pga_sequencer.sv
// Self-checking bench: pga_sequencer paired with a divide-by-10 serializer
// model and a comparator model; packets are checked against a scoreboard.
module tb_pga_sequencer;

  localparam int SETTLE = 100;
  localparam int ACK_TO = 255;

  logic       clk50 = 1'b0;
  logic       wb_rst;
  logic       start_write, start_cal;
  logic [4:0] cfg_offset;
  logic [3:0] cfg_gain;
  logic       cfg_shdn, cfg_meas;
  logic       cmp_in;
  logic       busy, done, error;
  logic [4:0] cal_offset;
  logic       cal_found;
  logic       pga_set_vos, pga_set_gain;
  logic [4:0] pga_offset;
  logic [3:0] pga_gain;
  logic       pga_shdn, pga_meas;
  logic       pga_ready = 1'b0;

  always #10 clk50 = ~clk50;

  pga_sequencer #(.SETTLE_CYCLES(SETTLE), .ACK_TIMEOUT(ACK_TO)) dut (
    .clk50(clk50), .wb_rst(wb_rst), .start_write(start_write), .start_cal(start_cal),
    .cfg_offset(cfg_offset), .cfg_gain(cfg_gain), .cfg_shdn(cfg_shdn), .cfg_meas(cfg_meas),
    .cmp_in(cmp_in), .busy(busy), .done(done), .error(error),
    .cal_offset(cal_offset), .cal_found(cal_found),
    .pga_set_vos(pga_set_vos), .pga_set_gain(pga_set_gain),
    .pga_offset(pga_offset), .pga_gain(pga_gain), .pga_shdn(pga_shdn), .pga_meas(pga_meas),
    .pga_ready(pga_ready)
  );

  typedef struct packed {
    logic       is_vos;
    logic [4:0] offset;
    logic [3:0] gain;
    logic       shdn;
    logic       meas;
  } pkt_t;

  typedef struct {
    logic [4:0] off;
    logic [3:0] gain;
    logic       shdn;
    logic       meas;
    int         exp_dones;
    logic       exp_error;
  } wr_vec_t;

  pkt_t    exp_q[$];
  wr_vec_t vecs[4];
  int      checks = 0;
  int      failures = 0;
  int      vos_pkts = 0;
  int      sweep_writes = 0;
  int      cmp_trip = 32;
  logic    stall = 1'b0;

  // Comparator trips once the applied offset reaches cmp_trip (32 = never).
  assign cmp_in = (cmp_trip < 32) && (int'(pga_offset) >= cmp_trip);

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic pkt_t mask_pkt(input pkt_t p);
    pkt_t r = p;
    if (!r.is_vos) r.offset = '0;
    return r;
  endfunction

  // Serializer model: ticks every 10 clk50 cycles, 8 ticks per packet.
  int   div_cnt = 0;
  int   link_cnt = 0;
  int   bits_left = 0;
  pkt_t cur;
  pkt_t exp_pkt;

  always @(negedge clk50) begin
    if (wb_rst) begin
      div_cnt   = 0;
      link_cnt  = 0;
      bits_left = 0;
      pga_ready <= 1'b0;
    end else if (div_cnt != 9) begin
      div_cnt++;
    end else begin
      div_cnt = 0;
      if (link_cnt < 3) begin
        link_cnt++;
        if (link_cnt == 3) pga_ready <= 1'b1;
      end else if (stall) begin
        pga_ready <= 1'b1;
      end else if (pga_ready && (pga_set_vos || pga_set_gain)) begin
        checkOutput("one_request", 32'(pga_set_vos & pga_set_gain), 0);
        cur = '{is_vos: pga_set_vos, offset: pga_offset, gain: pga_gain,
                shdn: pga_shdn, meas: pga_meas};
        bits_left = 8;
        pga_ready <= 1'b0;
      end else if (!pga_ready) begin
        bits_left--;
        if (bits_left == 0) begin
          pga_ready <= 1'b1;
          checkOutput("fields_stable", 32'({pga_offset, pga_gain, pga_shdn, pga_meas}),
                      32'({cur.offset, cur.gain, cur.shdn, cur.meas}));
          checkOutput("pkt_expected", 32'(exp_q.size() != 0), 1);
          if (exp_q.size() != 0) begin
            exp_pkt = exp_q.pop_front();
            checkOutput("pkt", 32'(mask_pkt(cur)), 32'(mask_pkt(exp_pkt)));
          end
          if (cur.is_vos) vos_pkts++;
          if (cur.is_vos && cur.meas) sweep_writes++;
        end
      end
    end
  end

  task automatic push_write(input logic [4:0] off, input logic [3:0] g, input logic s, input logic m);
    exp_q.push_back('{is_vos: 1'b0, offset: off, gain: g, shdn: s, meas: m});
    exp_q.push_back('{is_vos: 1'b1, offset: off, gain: g, shdn: s, meas: m});
  endtask

  task automatic push_cal(input logic [3:0] g, input logic s, input logic m, input int trip);
    int last = (trip < 32) ? trip : 31;
    exp_q.push_back('{is_vos: 1'b0, offset: 5'd0, gain: g, shdn: s, meas: 1'b1});
    for (int k = 0; k <= last; k++)
      exp_q.push_back('{is_vos: 1'b1, offset: 5'(k), gain: g, shdn: s, meas: 1'b1});
    exp_q.push_back('{is_vos: 1'b1, offset: 5'(last), gain: g, shdn: s, meas: m});
  endtask

  // One-cycle start pulse; cfg_* is scrambled afterwards so only latched values can be used.
  task automatic applyStimulus(input logic wr, input logic cal, input logic [4:0] off,
                               input logic [3:0] g, input logic s, input logic m,
                               input int trip, input logic expect_pkts);
    @(negedge clk50);
    start_write = wr;
    start_cal   = cal;
    cfg_offset  = off;
    cfg_gain    = g;
    cfg_shdn    = s;
    cfg_meas    = m;
    cmp_trip    = trip;
    if (expect_pkts) begin
      if (cal) push_cal(g, s, m, trip);
      else if (wr) push_write(off, g, s, m);
    end
    @(negedge clk50);
    start_write = 1'b0;
    start_cal   = 1'b0;
    cfg_offset  = ~off;
    cfg_gain    = ~g;
    cfg_shdn    = ~s;
    cfg_meas    = ~m;
  endtask

  task automatic wait_idle(input int budget, output int dones);
    int cycles = 0;
    dones = 0;
    do begin
      @(negedge clk50);
      cycles++;
      if (done) dones++;
    end while (busy && cycles < budget);
    checkOutput("seq_finished", 32'(busy), 0);
  endtask

  initial begin
    int   dones, n, ready_at, base, c;
    logic early_req;

    vecs[0] = '{5'h15, 4'h6, 1'b0, 1'b0, 1, 1'b0};
    vecs[1] = '{5'h00, 4'h0, 1'b1, 1'b1, 1, 1'b0};
    vecs[2] = '{5'h1f, 4'hf, 1'b0, 1'b1, 1, 1'b0};
    vecs[3] = '{5'h0a, 4'h9, 1'b1, 1'b0, 1, 1'b0};

    wb_rst = 1'b1; start_write = 1'b0; start_cal = 1'b0;
    cfg_offset = '0; cfg_gain = '0; cfg_shdn = 1'b0; cfg_meas = 1'b0;
    repeat (3) @(negedge clk50);
    checkOutput("rst_busy", 32'(busy), 1);
    checkOutput("rst_done", 32'(done), 0);
    checkOutput("rst_error", 32'(error), 0);
    checkOutput("rst_pga", 32'({pga_set_vos, pga_set_gain, pga_offset, pga_gain, pga_shdn, pga_meas}), 0);
    checkOutput("rst_cal", 32'({cal_offset, cal_found}), 0);

    $display("[TB] link bring-up");
    wb_rst = 1'b0;
    early_req = 1'b0; ready_at = -1; n = 0;
    do begin
      @(negedge clk50);
      n++;
      if (pga_set_vos || pga_set_gain) early_req = 1'b1;
      if (pga_ready && ready_at < 0) ready_at = n;
    end while (busy && n < 500);
    checkOutput("link_up", 32'(busy), 0);
    checkOutput("link_no_early_req", 32'(early_req), 0);
    checkOutput("link_busy_lag", 32'(n - ready_at), 2);

    $display("[TB] calibration, trip at 9");
    applyStimulus(1'b0, 1'b1, 5'h03, 4'h5, 1'b0, 1'b0, 9, 1'b1);
    sweep_writes = 0;
    wait_idle(20000, dones);
    checkOutput("cal9_dones", 32'(dones), 1);
    checkOutput("cal9_error", 32'(error), 0);
    checkOutput("cal9_offset", 32'(cal_offset), 9);
    checkOutput("cal9_found", 32'(cal_found), 1);
    checkOutput("cal9_sweeps", 32'(sweep_writes), 10);
    checkOutput("cal9_queue", 32'(exp_q.size()), 0);

    $display("[TB] write vectors");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, vecs[i].off, vecs[i].gain, vecs[i].shdn, vecs[i].meas, 32, 1'b1);
      wait_idle(2000, dones);
      checkOutput($sformatf("wr%0d_dones", i), 32'(dones), 32'(vecs[i].exp_dones));
      checkOutput($sformatf("wr%0d_error", i), 32'(error), 32'(vecs[i].exp_error));
      checkOutput($sformatf("wr%0d_cal_kept", i), 32'({cal_offset, cal_found}), 32'({5'd9, 1'b1}));
      checkOutput($sformatf("wr%0d_queue", i), 32'(exp_q.size()), 0);
    end

    $display("[TB] calibration, comparator stuck low");
    applyStimulus(1'b0, 1'b1, 5'h11, 4'h2, 1'b0, 1'b0, 32, 1'b1);
    sweep_writes = 0;
    wait_idle(30000, dones);
    checkOutput("cal31_dones", 32'(dones), 1);
    checkOutput("cal31_offset", 32'(cal_offset), 31);
    checkOutput("cal31_found", 32'(cal_found), 0);
    checkOutput("cal31_sweeps", 32'(sweep_writes), 32);
    checkOutput("cal31_queue", 32'(exp_q.size()), 0);

    $display("[TB] serializer stalled");
    stall = 1'b1;
    applyStimulus(1'b1, 1'b0, 5'h15, 4'h6, 1'b0, 1'b0, 32, 1'b0);
    c = 0;
    do begin
      @(negedge clk50);
      c++;
    end while (!error && c < 400);
    checkOutput("timeout_cycles", 32'(c), 255);
    checkOutput("timeout_done", 32'(done), 1);
    checkOutput("timeout_req_dropped", 32'({pga_set_vos, pga_set_gain}), 0);
    @(negedge clk50);
    checkOutput("timeout_linkwait_busy", 32'({busy, done}), 32'({1'b1, 1'b0}));
    wait_idle(500, dones);
    stall = 1'b0;
    checkOutput("error_sticky", 32'(error), 1);
    checkOutput("timeout_cal_kept", 32'({cal_offset, cal_found}), 32'({5'd31, 1'b0}));

    $display("[TB] simultaneous starts, then start while busy");
    applyStimulus(1'b1, 1'b1, 5'h07, 4'h3, 1'b1, 1'b1, 4, 1'b1);
    checkOutput("error_cleared", 32'(error), 0);
    repeat (5) @(negedge clk50);
    start_write = 1'b1; cfg_offset = 5'h1b; cfg_gain = 4'hc; cfg_meas = 1'b0;
    @(negedge clk50);
    start_write = 1'b0;
    wait_idle(20000, dones);
    checkOutput("prio_dones", 32'(dones), 1);
    checkOutput("prio_cal", 32'({cal_offset, cal_found}), 32'({5'd4, 1'b1}));
    repeat (300) @(negedge clk50);
    checkOutput("prio_queue", 32'(exp_q.size()), 0);
    checkOutput("prio_idle", 32'(busy), 0);

    $display("[TB] reset mid-sweep");
    base = vos_pkts;
    applyStimulus(1'b0, 1'b1, 5'h00, 4'h1, 1'b0, 1'b0, 32, 1'b1);
    c = 0;
    while (vos_pkts < base + 3 && c < 5000) begin
      @(negedge clk50);
      c++;
    end
    checkOutput("sweep_progress", 32'(vos_pkts >= base + 3), 1);
    wb_rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 1);
    checkOutput("midrst_flags", 32'({done, error}), 0);
    checkOutput("midrst_pga", 32'({pga_set_vos, pga_set_gain, pga_offset, pga_gain, pga_shdn, pga_meas}), 0);
    checkOutput("midrst_cal", 32'({cal_offset, cal_found}), 0);
    exp_q.delete();
    repeat (3) @(negedge clk50);
    exp_q.delete();
    wb_rst = 1'b0;
    wait_idle(500, dones);
    checkOutput("midrst_no_done", 32'(dones), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pga_sequencer.md
PGA_SEQUENCER -- requirements
Module: pga_sequencer

Interface
REQ-001 The block SHALL have one clock and one reset; reset is asynchronous and active-high, with ports named clk50 and wb_rst as elsewhere in the codebase.
REQ-002 Parameter SETTLE_CYCLES, 1000, clk50 cycles to wait after each calibration offset write before sampling the comparator.
REQ-003 Parameter ACK_TIMEOUT, 255, maximum clk50 cycles to wait for each pga_ready edge.
REQ-004 The ports SHALL be, one per line (name, direction, width, meaning):
- clk50  in  1  50 MHz clock
- wb_rst  in  1  asynchronous active-high reset
- start_write  in  1  one-cycle pulse: write cfg_* to the PGA
- start_cal  in  1  one-cycle pulse: run the offset calibration sweep
- cfg_offset  in  5  offset for start_write
- cfg_gain  in  4  gain code
- cfg_shdn  in  1  shutdown bit
- cfg_meas  in  1  measure bit for normal writes
- cmp_in  in  1  asynchronous comparator output; 1 means output above mid-scale
- busy  out  1  sequence in progress, or PGA link not yet ready
- done  out  1  one-cycle pulse at the end of a sequence
- error  out  1  sticky ACK timeout flag; cleared by the next start
- cal_offset  out  5  offset chosen by the last calibration
- cal_found  out  1  comparator trip found during the last calibration
- pga_set_vos  out  1  request to the PGA serializer: offset packet
- pga_set_gain  out  1  request to the PGA serializer: gain packet
- pga_offset  out  5  offset field to the serializer
- pga_gain  out  4  gain field to the serializer
- pga_shdn  out  1  shutdown field
- pga_meas  out  1  measure field
- pga_ready  in  1  serializer idle; runs on the divided PGA clock

Function
REQ-005 pga_ready and cmp_in SHALL each pass through a two-flop synchronizer; all decisions SHALL use the synchronized values.
REQ-006 The FSM states SHALL be LINK_WAIT, IDLE, VOS_REQ, VOS_ACK, GAIN_REQ, GAIN_ACK, SETTLE, SAMPLE, FINAL_VOS, DONE.
REQ-007 LINK_WAIT: busy=1; exit to IDLE on the first synchronized pga_ready=1; ignore starts while in this state.
REQ-008 IDLE: busy=0.
- start_cal takes priority over start_write when both are asserted in the same cycle.
- Either start SHALL latch cfg_* and clear error.
- Starts asserted while busy=1 SHALL be ignored (no queuing).
REQ-009 Write sequence: GAIN_REQ, GAIN_ACK, VOS_REQ, VOS_ACK, DONE, using the latched cfg_* fields.
REQ-010 Request handshake (*_REQ): hold the request (pga_set_vos or pga_set_gain) at 1 until synchronized pga_ready=0 is seen, then drop it and enter *_ACK. *_ACK waits for synchronized pga_ready=1. Only one request SHALL be high at a time.
REQ-011 Each *_REQ and *_ACK wait SHALL time out after ACK_TIMEOUT cycles. On timeout:
- set error=1
- drop all requests
- go to DONE, then to LINK_WAIT (not IDLE)
REQ-012 The pga_* fields SHALL be stable from the cycle a request rises until pga_ready returns to 1.
REQ-013 Calibration sequence:
- Gain write with pga_meas=1.
- Offset sweep for k = 0..31, in order. For each k: VOS write with offset k, meas=1; SETTLE for SETTLE_CYCLES; SAMPLE.
- At the first k where synchronized cmp_in=1: set cal_offset=k and cal_found=1, then stop the sweep.
- If no trip occurs by k=31: set cal_offset=31 and cal_found=0.
- Finish with FINAL_VOS: a VOS write with cal_offset and meas=cfg_meas, then DONE.
REQ-014 The sweep counter SHALL be 5 bits and SHALL NOT wrap; k=31 without a trip terminates the sweep.
REQ-015 DONE: assert done for exactly one cycle, then enter IDLE (or LINK_WAIT after a timeout).
REQ-016 cal_offset and cal_found SHALL update only at the end of a calibration; a write sequence SHALL leave them unchanged.

Reset
REQ-017 On wb_rst, asynchronously:
- state=LINK_WAIT, busy=1
- done=0, error=0
- all pga_* outputs=0
- cal_offset=0, cal_found=0
- all counters and synchronizers cleared
REQ-018 wb_rst mid-sequence SHALL abort immediately with no partial completion; the serializer is reset by the same wb_rst.

Structure
REQ-019 Shared package pga_pkg SHALL hold the FSM state encoding, the field widths (offset 5, gain 4), and the SETTLE_CYCLES and ACK_TIMEOUT defaults.
REQ-020 Sub-module pga_sync2 (two-flop synchronizer) SHALL be instantiated twice; the FSM, counters and datapath SHALL be flat in pga_sequencer.

Verification
REQ-021 Bench SHALL pair the block with the PGA serializer (divide-by-10 clock) and cover:
- Reset, then pga_ready rises: busy 1 until about 2 cycles after pga_ready=1; no request issued before that.
- start_write with offset=0x15, gain=0x6, shdn=0, meas=0: gain packet, then vos packet; one done pulse; error=0.
- start_cal with a comparator model tripping at k>=9: 10 sweep writes, cal_offset=9, cal_found=1; the final vos write carries meas=0.
- start_cal with cmp_in stuck at 0: 32 sweep writes, cal_offset=31, cal_found=0; no wrap to 0.
- pga_ready held at 1 (serializer stalled) during start_write: error=1 after 255 cycles, requests dropped, state returns to LINK_WAIT.
- start_write and start_cal in the same cycle, then a start_write while busy: calibration runs; the second start is ignored; wb_rst mid-sweep zeroes all outputs.
